adq_spi_master: RTL and testbench
=================================

ADQ_SPI_MASTER -- requirements
Module: adq_spi_master

Interface
REQ-001 The block SHALL have parameter ClkDivHalf, default 4, meaning the SCK half-period in clk_i cycles; values below 2 SHALL be treated as 2.
REQ-002 The block SHALL have port clk_i  input  1  single system clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port cmd_valid_i  input  1  command request.
REQ-005 The block SHALL have port cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-006 The block SHALL have port cmd_rd_i  input  1  1 = register read, 0 = register write.
REQ-007 The block SHALL have port cmd_addr_i  input  15  register address.
REQ-008 The block SHALL have port cmd_data_i  input  16  write data; ignored for reads.
REQ-009 The block SHALL have port rsp_valid_o  output  1  one-cycle pulse, read data valid.
REQ-010 The block SHALL have port rsp_data_o  output  16  read data.
REQ-011 The block SHALL have port busy_o  output  1  high while a frame is in progress.
REQ-012 The block SHALL have ports SCK_o, SSEL_o and MOSI_o  output  1 each  SPI clock, active-low select and master data; and port MISO_i  input  1  slave data.

Function
REQ-013 Let H = ClkDivHalf. Frame = 32 bits, MSB first: bit31 = cmd_rd_i, bits30:16 = cmd_addr_i, bits15:0 = cmd_data_i for writes or 0 for reads.
REQ-014 SPI mode 0: SCK_o SHALL idle low; MOSI_o SHALL change only with the falling SCK_o; the slave samples on the rising SCK_o.
REQ-015 States SHALL be IDLE, SETUP, XFER, HOLD and GAP; cmd_ready_o SHALL be high only in IDLE; busy_o SHALL equal the negation of cmd_ready_o.
REQ-016 IDLE -> SETUP on the edge where cmd_valid_i && cmd_ready_o; command fields SHALL be latched on that edge; next cycle SSEL_o = 0 and MOSI_o = bit31.
REQ-017 SETUP SHALL last H cycles with SCK_o low, then go to XFER.
REQ-018 XFER SHALL produce exactly 32 SCK periods, each H cycles high followed by H cycles low.
REQ-019 MISO_i SHALL be sampled into the receive shift register on the clk_i edge that drives SCK_o from high to low; MOSI_o SHALL advance to the next bit on that same edge, except after bit 0.
REQ-020 After the 32nd low half-period the block SHALL enter HOLD (H cycles, SSEL_o low, SCK_o low), then GAP (H cycles, SSEL_o high), then IDLE.
REQ-021 cmd_ready_o SHALL reassert exactly 67*H cycles after the accepting edge, and back-to-back commands SHALL be separated by SSEL_o high for at least H cycles.
REQ-022 For reads, rsp_valid_o SHALL pulse high for exactly one cycle on entry to GAP, with rsp_data_o = the last 16 MISO samples (first sample = bit 15); for writes, rsp_valid_o SHALL stay low.
REQ-023 rsp_data_o SHALL hold its value until the next read response.
REQ-024 cmd_valid_i asserted while busy SHALL be ignored (no queuing), and command inputs SHALL be don't-care outside the accepting edge.
REQ-025 MOSI_o SHALL be 0 whenever SSEL_o is high.

Reset
REQ-026 While rst_i is high at a clk_i edge: state = IDLE, SCK_o = 0, SSEL_o = 1, MOSI_o = 0, rsp_valid_o = 0, rsp_data_o = 0, cmd_ready_o = 1 after the edge, busy_o = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame within one cycle, with no rsp_valid_o pulse; a command presented on the same edge as rst_i SHALL NOT be accepted.

Verification
REQ-028 H=4, write addr 0x1234 data 0xBEEF -> MOSI stream 0x1234BEEF (bit31 = 0), 32 SCK rising edges, SSEL_o low for 66*4 cycles, no rsp_valid_o, cmd_ready_o back at cycle 268.
REQ-029 H=4, read addr 0x0010, slave model drives 0xA5C3 on bits 15:0 -> MOSI 0x80100000, single rsp_valid_o pulse with rsp_data_o = 0xA5C3.
REQ-030 cmd_valid_i held high continuously with two writes -> two frames, SSEL_o high for at least 4 cycles between them, and the second command is accepted only when cmd_ready_o = 1.
REQ-031 rst_i pulsed for 1 cycle during bit 20 of a read -> SSEL_o = 1 and SCK_o = 0 on the next cycle, no rsp_valid_o, and a subsequent write completes normally.
REQ-032 ClkDivHalf=1 -> behaviour identical to H=2 (SCK period of 4 cycles, frame of 134 cycles).
REQ-033 SCK/SSEL protocol checker SHALL run in all tests: no SCK_o edges while SSEL_o is high, and MOSI_o stable while SCK_o is high.

Source files
------------

// File: rtl/adq_spi_master.sv
// SPI mode-0 register-access master.
// Each accepted command becomes one 32-bit frame, MSB first:
//   {rd, addr[14:0], rd ? 16'h0000 : data[15:0]}
// The frame runs SETUP (H), 32 SCK periods (2H each), HOLD (H) and GAP (H),
// so cmd_ready_o comes back exactly 67*H cycles after the accepting edge.
// For reads, the last 16 MISO samples are returned with a one-cycle
// rsp_valid_o pulse on entry to GAP.
//
// Handshake: a command transfers on a rising clk_i edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_ready_o is high only while idle, commands
// offered while busy are simply not taken, and command inputs are only
// looked at on the accepting edge.
module adq_spi_master #(
    parameter int ClkDivHalf = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rd_i,
    input  logic [14:0] cmd_addr_i,
    input  logic [15:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        busy_o,
    output logic        SCK_o,
    output logic        SSEL_o,
    output logic        MOSI_o,
    input  logic        MISO_i
);

    // Half-period clamped to 2 so SCK always has a distinct high and low phase.
    localparam int H  = (ClkDivHalf < 2) ? 2 : ClkDivHalf;
    localparam int CW = $clog2(H);
    localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;       // cycles spent in the current half-period/phase
    logic [4:0]      bit_q;       // index of the SCK period in progress (0..31)
    logic [30:0]     tx_q;        // frame bits not yet on MOSI, next bit at [30]
    logic [15:0]     rx_q;        // most recent 16 MISO samples
    logic            rd_q;        // current frame is a read
    logic            sck_q;
    logic            ssel_q;
    logic            mosi_q;
    logic            ready_q;
    logic            rsp_valid_q;
    logic [15:0]     rsp_data_q;

    // Frame sequencer: every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_q        <= 1'b0;
            sck_q       <= 1'b0;
            ssel_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        // First frame bit goes straight to MOSI; the rest waits in tx_q.
                        tx_q    <= {cmd_addr_i, (cmd_rd_i ? 16'h0000 : cmd_data_i)};
                        rd_q    <= cmd_rd_i;
                        mosi_q  <= cmd_rd_i;
                        ssel_q  <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XFER: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (sck_q) begin
                            // Falling SCK: capture MISO and present the next bit.
                            sck_q <= 1'b0;
                            rx_q  <= {rx_q[14:0], MISO_i};
                            if (bit_q != 5'd31) begin
                                mosi_q <= tx_q[30];
                                tx_q   <= {tx_q[29:0], 1'b0};
                            end
                        end else if (bit_q == 5'd31) begin
                            state_q <= HOLD;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                            sck_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        ssel_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= GAP;
                        if (rd_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    sck_q   <= 1'b0;
                    ssel_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign SCK_o       = sck_q;
    assign SSEL_o      = ssel_q;
    assign MOSI_o      = mosi_q;

endmodule

// File: tb/tb_adq_spi_master.sv
// Bench for adq_spi_master: instance 0 at ClkDivHalf=4, instance 1 at
// ClkDivHalf=1 (expected to behave as H=2). Drivers push the expected frame
// into exp_q on acceptance; a negedge monitor rebuilds each frame from the
// SPI pins and compares it when SSEL rises, alongside protocol checks.
module tb_adq_spi_master;

    typedef struct packed {
        logic        inst;
        logic        rd;
        logic [31:0] mosi;
        logic [15:0] rsp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_rd;
    logic [14:0] cmd_addr [2];
    logic [15:0] cmd_data [2];
    logic [1:0]  miso;
    wire  [1:0]  cmd_ready;
    wire  [1:0]  rsp_valid;
    wire  [15:0] rsp_data0;
    wire  [15:0] rsp_data1;
    wire  [1:0]  busy;
    wire  [1:0]  sck;
    wire  [1:0]  ssel;
    wire  [1:0]  mosi;

    adq_spi_master #(.ClkDivHalf(4)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
        .cmd_rd_i(cmd_rd[0]), .cmd_addr_i(cmd_addr[0]), .cmd_data_i(cmd_data[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data0), .busy_o(busy[0]),
        .SCK_o(sck[0]), .SSEL_o(ssel[0]), .MOSI_o(mosi[0]), .MISO_i(miso[0])
    );

    adq_spi_master #(.ClkDivHalf(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
        .cmd_rd_i(cmd_rd[1]), .cmd_addr_i(cmd_addr[1]), .cmd_data_i(cmd_data[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data1), .busy_o(busy[1]),
        .SCK_o(sck[1]), .SSEL_o(ssel[1]), .MOSI_o(mosi[1]), .MISO_i(miso[1])
    );

    int compared = 0;
    int mismatched = 0;
    exp_t exp_q[$];
    logic [31:0] slave_q[$];

    // Monitor / slave state, one slot per instance
    logic        mon_en = 1'b0;
    logic        prev_sck [2];
    logic        prev_ssel [2];
    logic        prev_mosi [2];
    logic        track [2];
    logic        aborting [2];
    int          lat [2];
    int          low_cnt [2];
    int          high_cnt [2];
    int          sck_rise [2];
    int          frames [2];
    int          slv_idx [2];
    logic [31:0] mosi_w [2];
    logic [31:0] slv_w [2];
    logic [15:0] last_rsp [2];

    function automatic int h_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [15:0] rdata(input int k);
        return (k == 0) ? rsp_data0 : rsp_data1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (inst %0d): got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- monitor, scoreboard and slave model ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy_is_not_ready", k, busy[k], !cmd_ready[k]);

                // cmd_ready must return exactly 67*H cycles after acceptance
                if (rst[k]) begin
                    track[k] = 1'b0;
                end else if (track[k]) begin
                    if (cmd_ready[k]) begin
                        chk("ready_latency", k, lat[k], 67 * h_of(k));
                        track[k] = 1'b0;
                    end else begin
                        lat[k]++;
                    end
                end
                if (!rst[k] && cmd_valid[k] && cmd_ready[k]) begin
                    track[k] = 1'b1;
                    lat[k]   = 0;
                end

                // pin-level protocol rules
                if (prev_ssel[k] && ssel[k]) chk("sck_quiet_when_deselected", k, sck[k], prev_sck[k]);
                if (prev_sck[k] && sck[k])   chk("mosi_stable_sck_high", k, mosi[k], prev_mosi[k]);
                if (ssel[k])                 chk("mosi_zero_when_deselected", k, mosi[k], 0);

                // what the slave sees on each rising SCK
                if (!prev_sck[k] && sck[k]) begin
                    sck_rise[k]++;
                    mosi_w[k] = {mosi_w[k][30:0], mosi[k]};
                end

                // slave: load word on select, shift MSB-first after each falling SCK
                if (prev_ssel[k] && !ssel[k]) begin
                    if (frames[k] > 0) chk("gap_ssel_high_cycles", k, (high_cnt[k] >= h_of(k)), 1);
                    low_cnt[k]  = 0;
                    sck_rise[k] = 0;
                    slv_w[k]    = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                    slv_idx[k]  = 31;
                    miso[k]     = slv_w[k][31];
                end else if (!ssel[k] && prev_sck[k] && !sck[k]) begin
                    slv_idx[k]--;
                    if (slv_idx[k] >= 0) miso[k] = slv_w[k][slv_idx[k]];
                end

                // end of frame
                if (!prev_ssel[k] && ssel[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", k, 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("frame_instance", k, k, e.inst);
                        if (aborting[k]) begin
                            chk("abort_no_rsp_valid", k, rsp_valid[k], 0);
                            aborting[k] = 1'b0;
                        end else begin
                            chk("mosi_frame", k, mosi_w[k], e.mosi);
                            chk("sck_rising_edges", k, sck_rise[k], 32);
                            chk("ssel_low_cycles", k, low_cnt[k], 66 * h_of(k));
                            chk("rsp_valid_on_gap", k, rsp_valid[k], e.rd);
                            if (e.rd) begin
                                chk("rsp_data", k, rdata(k), e.rsp);
                                last_rsp[k] = e.rsp;
                            end else begin
                                chk("rsp_data_held", k, rdata(k), last_rsp[k]);
                            end
                        end
                    end
                    frames[k]++;
                    high_cnt[k] = 0;
                end else if (rsp_valid[k]) begin
                    chk("stray_rsp_valid", k, 1, 0);
                end

                if (ssel[k]) high_cnt[k]++;
                else         low_cnt[k]++;
                prev_sck[k]  = sck[k];
                prev_ssel[k] = ssel[k];
                prev_mosi[k] = mosi[k];
            end
        end
    end

    // ---------------- driver tasks (called at #1 after a posedge) ----------------
    task automatic send(input int k, input logic rd, input logic [14:0] addr,
                        input logic [15:0] data, input logic [31:0] sword, input bit hold);
        int   guard;
        logic acc;
        exp_t e;
        guard = 0;
        acc   = 1'b0;
        cmd_rd[k]    = rd;
        cmd_addr[k]  = addr;
        cmd_data[k]  = data;
        cmd_valid[k] = 1'b1;
        while (!acc && guard < 2000) begin
            acc = cmd_ready[k] && !rst[k];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            chk("accept_timeout", k, 0, 1);
        end else begin
            e.inst = k[0];
            e.rd   = rd;
            e.mosi = {rd, addr, (rd ? 16'h0000 : data)};
            e.rsp  = sword[15:0];
            exp_q.push_back(e);
            slave_q.push_back(sword);
        end
        if (!hold) begin
            cmd_valid[k] = 1'b0;
            cmd_rd[k]    = 1'($urandom_range(0, 1));
            cmd_addr[k]  = 15'($urandom);
            cmd_data[k]  = 16'($urandom);
        end
    endtask

    task automatic wait_idle(input int k);
        int guard;
        guard = 0;
        while ((!cmd_ready[k] || exp_q.size() != 0) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) chk("idle_timeout", k, 0, 1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic abort_read();
        send(0, 1'b1, 15'h0555, 16'h0000, 32'h1234_5678, 1'b0);
        repeat (170) @(posedge clk);
        #1;
        aborting[0] = 1'b1;
        rst[0]      = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("abort_ssel_high", 0, ssel[0], 1);
        chk("abort_sck_low", 0, sck[0], 0);
        chk("abort_ready", 0, cmd_ready[0], 1);
        chk("abort_rsp_data_cleared", 0, rsp_data0, 0);
        last_rsp[0] = 16'h0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic random_cmds(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            send(k, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)),
                 16'($urandom), $urandom, 1'b0);
            wait_idle(k);
        end
    endtask

    // ---------------- clock/reset and test sequence ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            prev_sck[k] = 1'b0; prev_ssel[k] = 1'b1; prev_mosi[k] = 1'b0;
            track[k] = 1'b0; aborting[k] = 1'b0; lat[k] = 0;
            low_cnt[k] = 0; high_cnt[k] = 0; sck_rise[k] = 0; frames[k] = 0;
            slv_idx[k] = 0; mosi_w[k] = '0; slv_w[k] = '0; last_rsp[k] = '0;
            cmd_addr[k] = '0; cmd_data[k] = '0;
        end
        rst = 2'b11; cmd_valid = 2'b00; cmd_rd = 2'b00; miso = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", k, cmd_ready[k], 1);
            chk("reset_busy", k, busy[k], 0);
            chk("reset_sck", k, sck[k], 0);
            chk("reset_ssel", k, ssel[k], 1);
            chk("reset_mosi", k, mosi[k], 0);
            chk("reset_rsp_valid", k, rsp_valid[k], 0);
            chk("reset_rsp_data", k, rdata(k), 0);
        end
        rst = 2'b00;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // directed write and read at H=4
        send(0, 1'b0, 15'h1234, 16'hBEEF, $urandom, 1'b0);
        wait_idle(0);
        send(0, 1'b1, 15'h0010, 16'h5555, {16'($urandom), 16'hA5C3}, 1'b0);
        wait_idle(0);

        // cmd_valid held high across two back-to-back writes
        send(0, 1'b0, 15'h7001, 16'h1111, $urandom, 1'b1);
        send(0, 1'b0, 15'h0ABC, 16'h2222, $urandom, 1'b0);
        wait_idle(0);

        // reset in the middle of a read, then a normal write
        abort_read();
        send(0, 1'b0, 15'h3C3C, 16'h0F0F, $urandom, 1'b0);
        wait_idle(0);

        // command on the same edge as reset must not start a frame
        rst[0] = 1'b1;
        cmd_valid[0] = 1'b1;
        cmd_rd[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        cmd_valid[0] = 1'b0;
        chk("reset_edge_cmd_ignored_ssel", 0, ssel[0], 1);
        chk("reset_edge_cmd_ignored_ready", 0, cmd_ready[0], 1);
        last_rsp[0] = 16'h0;
        repeat (10) @(posedge clk);
        #1;

        random_cmds(0, 5);

        // ClkDivHalf=1 behaves as H=2
        send(1, 1'b0, 15'h1234, 16'hBEEF, $urandom, 1'b0);
        wait_idle(1);
        send(1, 1'b1, 15'h0010, 16'h0000, 32'hFFFF_A5C3, 1'b0);
        wait_idle(1);
        random_cmds(1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule
